// File: rtl/decode_ctrl_unit_pkg.sv
// Shared decode constants: opcodes, memory access codes and immediate formats.
// Also maps an opcode to the immediate format it carries.
package decode_ctrl_unit_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] RW_NONE = 4'b0000;
    localparam logic [3:0] RW_LB   = 4'b0001;
    localparam logic [3:0] RW_LH   = 4'b0010;
    localparam logic [3:0] RW_LW   = 4'b0011;
    localparam logic [3:0] RW_LBU  = 4'b0100;
    localparam logic [3:0] RW_LHU  = 4'b0101;
    localparam logic [3:0] RW_SB   = 4'b1001;
    localparam logic [3:0] RW_SH   = 4'b1010;
    localparam logic [3:0] RW_SW   = 4'b1011;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_U    = 3'b011,
        IMM_J    = 3'b100,
        IMM_NONE = 3'b111
    } imm_fmt_t;

    function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opc);
        imm_fmt_t fmt;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt = IMM_I;
            OPC_STORE:                                  fmt = IMM_S;
            OPC_BRANCH:                                 fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:                         fmt = IMM_U;
            OPC_JAL:                                    fmt = IMM_J;
            default:                                    fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/decode_ctrl_unit_imm_gen_core.sv
// Immediate generator: assembles the sign-extended immediate from instr[31:7].
// Input bit k of the instruction appears at instr_hi_i[k-7].
module imm_gen_core
    import decode_ctrl_unit_pkg::*;
(
    input  logic [24:0] instr_hi_i,
    input  imm_fmt_t    fmt_i,
    output logic [31:0] imm_o
);

    logic w_sign;
    assign w_sign = instr_hi_i[24];

    always_comb begin
        imm_o = 32'd0;
        case (fmt_i)
            IMM_I: imm_o = {{20{w_sign}}, instr_hi_i[24:13]};
            IMM_S: imm_o = {{20{w_sign}}, instr_hi_i[24:18], instr_hi_i[4:0]};
            IMM_B: imm_o = {{19{w_sign}}, w_sign, instr_hi_i[0], instr_hi_i[23:18],
                            instr_hi_i[4:1], 1'b0};
            IMM_U: imm_o = {instr_hi_i[24:5], 12'd0};
            IMM_J: imm_o = {{11{w_sign}}, w_sign, instr_hi_i[12:5], instr_hi_i[13],
                            instr_hi_i[23:14], 1'b0};
            default: imm_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_ctrl_unit.sv
// Decode control: memory access decode, immediate generation and load-use
// hazard detection against the instruction currently in EX.
module decode_ctrl_unit
    import decode_ctrl_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [29:0] instr_i,
    input  logic        busywait_i,
    input  logic        flush_i,
    output logic [3:0]  read_write_o,
    output logic        is_memory_o,
    output logic        is_load_o,
    output logic [31:0] imm_o,
    output logic        load_stall_o
);

    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [3:0]  w_rw;
    imm_fmt_t    w_fmt;

    logic        r_ex_is_load;
    logic [4:0]  r_ex_rd;

    assign w_instr  = {instr_i, 2'b11};
    assign w_opcode = w_instr[6:0];
    assign w_funct3 = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_rd     = w_instr[11:7];

    // Unlisted funct3 values fall through to RW_NONE, which also clears the flags.
    always_comb begin
        w_rw = RW_NONE;
        if (w_opcode == OPC_LOAD) begin
            case (w_funct3)
                3'b000:  w_rw = RW_LB;
                3'b001:  w_rw = RW_LH;
                3'b010:  w_rw = RW_LW;
                3'b100:  w_rw = RW_LBU;
                3'b101:  w_rw = RW_LHU;
                default: w_rw = RW_NONE;
            endcase
        end else if (w_opcode == OPC_STORE) begin
            case (w_funct3)
                3'b000:  w_rw = RW_SB;
                3'b001:  w_rw = RW_SH;
                3'b010:  w_rw = RW_SW;
                default: w_rw = RW_NONE;
            endcase
        end
    end

    assign read_write_o = w_rw;
    assign is_memory_o  = |w_rw;
    assign is_load_o    = ~w_rw[3] & (|w_rw);

    assign w_fmt = imm_fmt_of(w_opcode);

    imm_gen_core u_imm_gen_core (
        .instr_hi_i (w_instr[31:7]),
        .fmt_i      (w_fmt),
        .imm_o      (imm_o)
    );

    // rs2 is compared for every opcode; a false stall only costs one bubble.
    assign load_stall_o = r_ex_is_load & (r_ex_rd != 5'd0) &
                          ((r_ex_rd == w_rs1) | (r_ex_rd == w_rs2));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ex_is_load <= 1'b0;
            r_ex_rd      <= 5'd0;
        end else if (busywait_i) begin
            r_ex_is_load <= r_ex_is_load;
            r_ex_rd      <= r_ex_rd;
        end else if (flush_i || load_stall_o) begin
            r_ex_is_load <= 1'b0;
            r_ex_rd      <= 5'd0;
        end else begin
            r_ex_is_load <= is_load_o;
            r_ex_rd      <= w_rd;
        end
    end

endmodule

// File: tb/tb_decode_ctrl_unit.sv
// Bench for decode_ctrl_unit: directed decode/hazard sequences followed by
// randomized instruction streams checked against a behavioural model.
module tb_decode_ctrl_unit;

    logic        clk_i;
    logic        rst_i;
    logic [29:0] instr_i;
    logic        busywait_i;
    logic        flush_i;
    logic [3:0]  read_write_o;
    logic        is_memory_o;
    logic        is_load_o;
    logic [31:0] imm_o;
    logic        load_stall_o;

    int n_vec;
    int n_err;

    // Model of the instruction sitting in EX: is it a load, and where does it write.
    logic        m_ex_load;
    logic [4:0]  m_ex_dst;
    logic [31:0] cur_ins;

    decode_ctrl_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .instr_i      (instr_i),
        .busywait_i   (busywait_i),
        .flush_i      (flush_i),
        .read_write_o (read_write_o),
        .is_memory_o  (is_memory_o),
        .is_load_o    (is_load_o),
        .imm_o        (imm_o),
        .load_stall_o (load_stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_rw(input logic [31:0] w);
        logic [3:0] rw;
        rw = 4'd0;
        if (w[6:0] == 7'h03) begin
            case (w[14:12])
                3'd0: rw = 4'd1;
                3'd1: rw = 4'd2;
                3'd2: rw = 4'd3;
                3'd4: rw = 4'd4;
                3'd5: rw = 4'd5;
                default: rw = 4'd0;
            endcase
        end else if (w[6:0] == 7'h23) begin
            if (w[14:12] <= 3'd2) rw = 4'd9 + {1'b0, w[14:12]};
        end
        return rw;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic signed [31:0] s;
        logic [31:0] r;
        s = w;
        case (w[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: r = 32'(s >>> 20);
            7'h23: r = 32'((s >>> 25) <<< 5) | 32'(w[11:7]);
            7'h63: r = 32'((s >>> 31) <<< 12) | (32'(w[7]) << 11) |
                       (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            7'h37, 7'h17: r = w & 32'hFFFF_F000;
            7'h6F: r = 32'((s >>> 31) <<< 20) | (32'(w[19:12]) << 12) |
                       (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic ref_stall(input logic [31:0] w);
        return m_ex_load && (m_ex_dst != 5'd0) &&
               ((m_ex_dst == w[19:15]) || (m_ex_dst == w[24:20]));
    endfunction

    task automatic check_all(input logic [31:0] w);
        logic [3:0] rw;
        rw = ref_rw(w);
        chk("read_write", 32'(read_write_o), 32'(rw));
        chk("is_memory", 32'(is_memory_o), 32'(rw != 4'd0));
        chk("is_load", 32'(is_load_o), 32'((rw != 4'd0) && (rw < 4'd8)));
        chk("imm", imm_o, ref_imm(w));
        chk("load_stall", 32'(load_stall_o), 32'(ref_stall(w)));
    endtask

    // Drive at the falling edge, check once the combinational outputs settle.
    task automatic apply(input logic [31:0] w, input logic busy, input logic flush);
        @(negedge clk_i);
        rst_i      = 1'b1;
        instr_i    = w[31:2];
        busywait_i = busy;
        flush_i    = flush;
        cur_ins    = w;
        #1;
        check_all(w);
    endtask

    task automatic edge_update();
        logic st;
        st = ref_stall(cur_ins);
        @(posedge clk_i);
        if (!rst_i) begin
            m_ex_load = 1'b0;
            m_ex_dst  = 5'd0;
        end else if (busywait_i) begin
            // stalled memory: EX keeps its instruction
        end else if (flush_i || st) begin
            m_ex_load = 1'b0;
            m_ex_dst  = 5'd0;
        end else begin
            m_ex_load = (ref_rw(cur_ins) != 4'd0) && (ref_rw(cur_ins) < 4'd8);
            m_ex_dst  = cur_ins[11:7];
        end
    endtask

    task automatic step(input logic [31:0] w, input logic busy, input logic flush);
        apply(w, busy, flush);
        edge_update();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [10];
        logic [31:0] w;
        opcs = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h13, 7'h73, 7'h33};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = opcs[$urandom_range(0, 9)];
        else w[1:0] = 2'b11;
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    localparam logic [31:0] LW_X5  = 32'h0081_2283;
    localparam logic [31:0] LW_X0  = 32'h0001_2003;
    localparam logic [31:0] ADD_X5 = 32'h0012_8333;
    localparam logic [31:0] ADD_X0 = 32'h0010_0333;

    initial begin
        n_vec      = 0;
        n_err      = 0;
        m_ex_load  = 1'b0;
        m_ex_dst   = 5'd0;
        rst_i      = 1'b0;
        busywait_i = 1'b0;
        flush_i    = 1'b0;
        cur_ins    = LW_X5;
        instr_i    = LW_X5[31:2];
        #3;
        chk("reset_stall", 32'(load_stall_o), 32'd0);
        chk("reset_rw_follows", 32'(read_write_o), 32'h3);
        chk("reset_imm_follows", imm_o, 32'h8);
        edge_update();

        // Directed decode
        apply(LW_X5, 1'b0, 1'b0);
        chk("lw_rw", 32'(read_write_o), 32'h3);
        chk("lw_is_load", 32'(is_load_o), 32'd1);
        chk("lw_is_mem", 32'(is_memory_o), 32'd1);
        chk("lw_imm", imm_o, 32'h0000_0008);
        edge_update();
        apply(ADD_X5, 1'b0, 1'b0);
        chk("use_stall", 32'(load_stall_o), 32'd1);
        edge_update();
        apply(ADD_X5, 1'b0, 1'b0);
        chk("after_bubble", 32'(load_stall_o), 32'd0);
        edge_update();
        apply(32'h0051_2623, 1'b0, 1'b0);
        chk("sw_rw", 32'(read_write_o), 32'hB);
        chk("sw_is_load", 32'(is_load_o), 32'd0);
        chk("sw_imm", imm_o, 32'h0000_000C);
        edge_update();
        apply(32'hFE00_0EE3, 1'b0, 1'b0);
        chk("beq_imm", imm_o, 32'hFFFF_FFFC);
        edge_update();
        apply(32'h1234_50B7, 1'b0, 1'b0);
        chk("lui_imm", imm_o, 32'h1234_5000);
        edge_update();
        apply(32'h0000_3283, 1'b0, 1'b0);
        chk("bad_f3_rw", 32'(read_write_o), 32'd0);
        chk("bad_f3_mem", 32'(is_memory_o), 32'd0);
        edge_update();

        // Load to x0 never stalls
        step(LW_X0, 1'b0, 1'b0);
        apply(ADD_X0, 1'b0, 1'b0);
        chk("x0_no_stall", 32'(load_stall_o), 32'd0);
        edge_update();

        // Busywait holds the stall
        step(LW_X5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(ADD_X5, 1'b1, 1'b0);
            chk("busy_hold_stall", 32'(load_stall_o), 32'd1);
            edge_update();
        end
        apply(ADD_X5, 1'b0, 1'b0);
        chk("busy_release_stall", 32'(load_stall_o), 32'd1);
        edge_update();
        apply(ADD_X5, 1'b0, 1'b0);
        chk("busy_after_bubble", 32'(load_stall_o), 32'd0);
        edge_update();

        // Flush beats stall
        step(LW_X5, 1'b0, 1'b0);
        apply(ADD_X5, 1'b0, 1'b1);
        chk("flush_pre", 32'(load_stall_o), 32'd1);
        edge_update();
        apply(ADD_X5, 1'b0, 1'b0);
        chk("flush_post", 32'(load_stall_o), 32'd0);
        edge_update();

        // Asynchronous reset mid-stall
        step(LW_X5, 1'b0, 1'b0);
        apply(ADD_X5, 1'b0, 1'b0);
        chk("pre_reset_stall", 32'(load_stall_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("async_reset_stall", 32'(load_stall_o), 32'd0);
        m_ex_load = 1'b0;
        m_ex_dst  = 5'd0;
        edge_update();

        // Randomized stream
        for (int i = 0; i < 400; i++) begin
            step(rand_instr(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
